// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 interrupt-acknowledge sequencer:
// sequencer states, default INTA timing and the cycle-timer width.
package pic_pkg;

    localparam int unsigned INTA_LOW_CYCLES_DEF = 1;
    localparam int unsigned INTA_GAP_CYCLES_DEF = 1;
    localparam int unsigned RECOVERY_CYCLES_DEF = 2;
    localparam int unsigned TIMER_W             = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACK1,
        GAP,
        ACK2,
        HOLD,
        RECOVER
    } ack_state_e;

    // A timed state lasting N cycles loads N-1 and leaves on the edge that sees zero.
    function automatic logic [TIMER_W-1:0] cycles_to_load(input int unsigned cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/inta_cycle_timer.sv
// 4-bit loadable down-counter shared by every timed sequencer state.
// Saturates at zero; done is high while the count is zero.
module inta_cycle_timer
    import pic_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_value,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Issues the two-pulse INTA handshake to an 8259 PIC, captures the vector byte
// on the edge ending the second pulse and hands it to the CPU core.
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter int unsigned INTA_LOW_CYCLES = INTA_LOW_CYCLES_DEF,
    parameter int unsigned INTA_GAP_CYCLES = INTA_GAP_CYCLES_DEF,
    parameter int unsigned RECOVERY_CYCLES = RECOVERY_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       interrupt_to_cpu,
    input  logic       interrupt_enable,
    input  logic [7:0] data_bus,
    output logic       interrupt_acknowledge_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_ready,
    output logic       busy
);

    ack_state_e         state_q;
    logic               inta_n_q;
    logic [7:0]         vector_q;
    logic               vector_valid_q;
    logic               busy_q;

    logic               int_req;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_done;

    assign int_req = interrupt_to_cpu && interrupt_enable;

    inta_cycle_timer u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    // Timer reload on entry to each timed state; HOLD is untimed, and ACK2/RECOVER exit at zero.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch behind.
        timer_load  = 1'b0;
        timer_value = '0;
        case (state_q)
            IDLE: if (int_req) begin
                timer_load  = 1'b1;
                timer_value = cycles_to_load(INTA_LOW_CYCLES);
            end
            ACK1: if (timer_done) begin
                timer_load  = 1'b1;
                timer_value = cycles_to_load(INTA_GAP_CYCLES);
            end
            GAP: if (timer_done) begin
                timer_load  = 1'b1;
                timer_value = cycles_to_load(INTA_LOW_CYCLES);
            end
            HOLD: if (vector_valid_q && vector_ready) begin
                timer_load  = 1'b1;
                timer_value = cycles_to_load(RECOVERY_CYCLES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            inta_n_q       <= 1'b1;
            vector_q       <= 8'h00;
            vector_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (int_req) begin
                    state_q  <= ACK1;
                    inta_n_q <= 1'b0;
                    busy_q   <= 1'b1;
                end
                ACK1: if (timer_done) begin
                    state_q  <= GAP;
                    inta_n_q <= 1'b1;
                end
                GAP: if (timer_done) begin
                    state_q  <= ACK2;
                    inta_n_q <= 1'b0;
                end
                ACK2: if (timer_done) begin
                    state_q        <= HOLD;
                    inta_n_q       <= 1'b1;
                    vector_q       <= data_bus;
                    vector_valid_q <= 1'b1;
                end
                HOLD: if (vector_valid_q && vector_ready) begin
                    state_q        <= RECOVER;
                    vector_valid_q <= 1'b0;
                end
                RECOVER: if (timer_done) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q        <= IDLE;
                    inta_n_q       <= 1'b1;
                    vector_valid_q <= 1'b0;
                    busy_q         <= 1'b0;
                end
            endcase
        end
    end

    assign interrupt_acknowledge_n = inta_n_q;
    assign vector                  = vector_q;
    assign vector_valid            = vector_valid_q;
    assign busy                    = busy_q;

endmodule
